// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - multi-cycle ALU with iterative multiply and restoring divide
//
// Purpose:
//   Accepts two N-bit operands and a 4-bit opcode on a start/busy/done
//   handshake. Logic, add/sub and shift ops complete in one cycle.
//   MUL runs as N shift-add steps and DIV/MOD as N restoring-division steps.
//   The registered 2N-bit result and flags {NEG, ZERO, CARRY, OVF} hold
//   until the next done pulse.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   request, accepted only while busy=0
//   op_select  in   [3:0]   opcode, latched at accept
//   operand1   in   [N-1:0] operand A, latched at accept
//   operand2   in   [N-1:0] operand B / shift amount, latched at accept
//   busy       out  high from accept through the done cycle
//   done       out  one-cycle pulse, resultado/banderas valid
//   resultado  out  [2N-1:0] result (upper half zero except for MUL)
//   banderas   out  [3:0] {NEG, ZERO, CARRY, OVF}

module seq_alu #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [3:0]     op_select,
  input  logic [N-1:0]   operand1,
  input  logic [N-1:0]   operand2,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] resultado,
  output logic [3:0]     banderas
);

  localparam int W  = 2 * N;
  localparam int CW = $clog2(N);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_MOD = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_OR  = 4'd6;
  localparam logic [3:0] OP_XOR = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;

  localparam logic [N-1:0] N_LIM = N[N-1:0];

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      op_q, op_d;
  logic [N-1:0]    b_q, b_d;          // divisor; for MUL the multiplier, consumed LSB first
  logic [W-1:0]    mcand_q, mcand_d;  // multiplicand, shifted left each MUL step
  logic [W-1:0]    acc_q, acc_d;      // running product
  logic [N-1:0]    quo_q, quo_d;      // dividend bits leave MSB first, quotient bits enter LSB
  logic [N-1:0]    rem_q, rem_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    res_q, res_d;
  logic [3:0]      flg_q, flg_d;

  // single-cycle ALU, evaluated on the raw inputs in the accept cycle
  logic [N:0]      sum_ext, diff_ext, shl_ext, shr_ext;
  logic            big_shift;
  logic [N-1:0]    alu_res;
  logic            alu_carry, alu_ovf;

  // iterative datapath helpers
  logic [N:0]      div_shift;
  logic            div_fits;
  logic [W-1:0]    mul_sum;

  logic            load_res;
  logic [W-1:0]    new_res;
  logic            new_carry, new_ovf, new_is_mul, new_neg;

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      b_q     <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      flg_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      b_q     <= b_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op_select)
            OP_MUL:         state_d = S_MUL;
            OP_DIV, OP_MOD: state_d = S_DIV;
            default:        state_d = S_DONE;
          endcase
        end
      end
      S_MUL:   if (cnt_q == '0) state_d = S_DONE;
      S_DIV:   if (cnt_q == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // single-cycle operations
  always_comb begin
    sum_ext   = {1'b0, operand1} + {1'b0, operand2};
    diff_ext  = {1'b0, operand1} - {1'b0, operand2};
    // extra bit on the exit side captures the last bit shifted out
    shl_ext   = {1'b0, operand1} << operand2;
    shr_ext   = {operand1, 1'b0} >> operand2;
    big_shift = (operand2 >= N_LIM);
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (op_select)
      OP_ADD: begin
        alu_res   = sum_ext[N-1:0];
        alu_carry = sum_ext[N];
        alu_ovf   = (operand1[N-1] == operand2[N-1]) && (sum_ext[N-1] != operand1[N-1]);
      end
      OP_SUB: begin
        alu_res   = diff_ext[N-1:0];
        alu_carry = diff_ext[N];
        alu_ovf   = (operand1[N-1] != operand2[N-1]) && (diff_ext[N-1] != operand1[N-1]);
      end
      OP_AND: alu_res = operand1 & operand2;
      OP_OR:  alu_res = operand1 | operand2;
      OP_XOR: alu_res = operand1 ^ operand2;
      OP_SHL: begin
        if (!big_shift) begin
          alu_res   = shl_ext[N-1:0];
          alu_carry = shl_ext[N];
        end
      end
      OP_SHR: begin
        if (!big_shift) begin
          alu_res   = shr_ext[N:1];
          alu_carry = shr_ext[0];
        end
      end
      // reserved opcodes; MUL/DIV/MOD never take their result from here
      default: alu_ovf = 1'b1;
    endcase
  end

  // datapath next values and result capture
  always_comb begin
    op_d    = op_q;
    b_d     = b_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;

    div_shift = {rem_q, quo_q[N-1]};
    div_fits  = (div_shift >= {1'b0, b_q});
    mul_sum   = acc_q + (b_q[0] ? mcand_q : '0);

    load_res   = 1'b0;
    new_res    = '0;
    new_carry  = 1'b0;
    new_ovf    = 1'b0;
    new_is_mul = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op_select;
          b_d     = operand2;
          mcand_d = {{N{1'b0}}, operand1};
          acc_d   = '0;
          quo_d   = operand1;
          rem_d   = '0;
          cnt_d   = CW'(N - 1);
          if (state_d == S_DONE) begin
            load_res  = 1'b1;
            new_res   = {{N{1'b0}}, alu_res};
            new_carry = alu_carry;
            new_ovf   = alu_ovf;
          end
        end
      end
      S_MUL: begin
        acc_d   = mul_sum;
        mcand_d = mcand_q << 1;
        b_d     = b_q >> 1;
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          load_res   = 1'b1;
          new_res    = mul_sum;
          new_ovf    = |mul_sum[W-1:N];
          new_is_mul = 1'b1;
        end
      end
      S_DIV: begin
        // a zero divisor always "fits", giving all-ones quotient and remainder=A
        if (div_fits) begin
          rem_d = div_shift[N-1:0] - b_q;
          quo_d = {quo_q[N-2:0], 1'b1};
        end else begin
          rem_d = div_shift[N-1:0];
          quo_d = {quo_q[N-2:0], 1'b0};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          load_res = 1'b1;
          new_res  = (op_q == OP_DIV) ? {{N{1'b0}}, quo_d} : {{N{1'b0}}, rem_d};
          new_ovf  = (b_q == '0);
        end
      end
      default: ;
    endcase

    new_neg = new_is_mul ? new_res[W-1] : new_res[N-1];
    res_d   = load_res ? new_res : res_q;
    flg_d   = load_res ? {new_neg, (new_res == '0), new_carry, new_ovf} : flg_q;
  end

  // outputs
  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    resultado = res_q;
    banderas  = flg_q;
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - directed self-checking bench for seq_alu (N=4)

module tb_seq_alu;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] op_select;
  logic [3:0] operand1;
  logic [3:0] operand2;
  logic       busy;
  logic       done;
  logic [7:0] resultado;
  logic [3:0] banderas;

  int total = 0;
  int bad   = 0;

  seq_alu #(.N(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op_select (op_select),
    .operand1  (operand1),
    .operand2  (operand2),
    .busy      (busy),
    .done      (done),
    .resultado (resultado),
    .banderas  (banderas)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one op, scramble inputs right after accept, then measure latency
  // as the number of edges after accept at which done is first sampled high.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [3:0] a,
                        input logic [3:0] b, input int exp_lat,
                        input logic [7:0] exp_res, input logic [3:0] exp_flg);
    int lat;
    @(negedge clk);
    op_select = op;
    operand1  = a;
    operand2  = b;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    op_select = ~op;
    operand1  = ~a;
    operand2  = ~b;
    lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(negedge clk);
      if (done) lat = i;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_res"}, resultado, exp_res);
    check({tag, "_flg"}, banderas, exp_flg);
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;
    int lat;

    rst_n     = 1'b0;
    start     = 1'b0;
    op_select = 4'd0;
    operand1  = 4'd0;
    operand2  = 4'd0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_res", resultado, 8'h00);
    check("rst_flg", banderas, 4'h0);
    rst_n = 1'b1;

    // reset two edges into a DIV aborts it with no done
    @(negedge clk);
    op_select = 4'd3; operand1 = 4'd13; operand2 = 4'd4; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_res", resultado, 8'h00);
    done_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("midrst_nodone", done_cnt, 0);

    run_op("add_9_8", 4'd0, 4'd9, 4'd8, 1, 8'h01, 4'b0011);

    // MUL 15*15 with start pulses while busy
    @(negedge clk);
    op_select = 4'd2; operand1 = 4'd15; operand2 = 4'd15; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (lat == 0) begin
          lat = i;
          check("mul_res", resultado, 8'hE1);
          check("mul_flg", banderas, 4'b1001);
        end
      end
      start = (i <= 3);
    end
    start = 1'b0;
    check("mul_lat", lat, 5);
    check("mul_busy", busy_cnt, 5);
    check("mul_ndone", done_cnt, 1);

    run_op("div_13_4", 4'd3, 4'd13, 4'd4, 5, 8'h03, 4'b0000);
    run_op("mod_13_4", 4'd4, 4'd13, 4'd4, 5, 8'h01, 4'b0000);
    run_op("div_13_0", 4'd3, 4'd13, 4'd0, 5, 8'h0F, 4'b1001);
    run_op("mod_13_0", 4'd4, 4'd13, 4'd0, 5, 8'h0D, 4'b1001);
    run_op("sub_3_5",  4'd1, 4'd3,  4'd5, 1, 8'h0E, 4'b1010);
    run_op("xor_a_a",  4'd7, 4'hA,  4'hA, 1, 8'h00, 4'b0100);
    run_op("shl_b_1",  4'd8, 4'hB,  4'd1, 1, 8'h06, 4'b0010);
    run_op("shr_b_2",  4'd9, 4'hB,  4'd2, 1, 8'h02, 4'b0010);
    run_op("shl_b_5",  4'd8, 4'hB,  4'd5, 1, 8'h00, 4'b0100);
    run_op("rsv_12",   4'd12, 4'h3, 4'h5, 1, 8'h00, 4'b0101);
    run_op("mul_3_5",  4'd2, 4'd3,  4'd5, 5, 8'h0F, 4'b0000);

    // start held high: ADD 1+1, then AND 0xC&0xA re-accepted after one IDLE cycle
    @(negedge clk);
    op_select = 4'd0; operand1 = 4'd1; operand2 = 4'd1; start = 1'b1;
    @(posedge clk);
    #1;
    op_select = 4'd5; operand1 = 4'hC; operand2 = 4'hA;
    @(negedge clk);
    check("b2b_done1", done, 1'b1);
    check("b2b_res1", resultado, 8'h02);
    check("b2b_flg1", banderas, 4'b0000);
    @(negedge clk);
    check("b2b_idle_done", done, 1'b0);
    check("b2b_idle_busy", busy, 1'b0);
    @(negedge clk);
    check("b2b_done2", done, 1'b1);
    check("b2b_res2", resultado, 8'h08);
    check("b2b_flg2", banderas, 4'b1000);
    start = 1'b0;
    @(negedge clk);
    check("b2b_end_busy", busy, 1'b0);
    check("b2b_hold_res", resultado, 8'h08);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
